verinject_injection_sequencer: RTL and testbench

Drives the shared `verinject__injector_state` word that every flip-flop injector in an instrumented design compares against its own bit range. It accepts an injection job over a valid/ready handshake, counts a programmed delay, and then drives the selected global bit index for a programmed number of cycles. Outside that window it drives an out-of-range idle code. It sits between the testbench/host control interface and the injector fabric, one instance per instrumented design.

---
 rtl/verinject_injection_sequencer.sv | 154 +++++++++++++++
 tb/tb_verinject_injection_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/verinject_injection_sequencer.sv
// Drives the shared injector state word. A job arrives over valid/ready,
// waits a programmed delay, then holds a selected global bit index on the
// output for a programmed number of cycles before returning to the idle code.
// Optional macro VERINJECT_SEQ_REPEAT_EN: repeat the injection cfg_count
// times, cfg_period idle-delay apart, stepping the bit index each time.
module verinject_injection_sequencer #(
  parameter logic [31:0] IDLE_STATE = 32'hFFFF_FFFF,
  parameter int          CYCLE_W    = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CYCLE_W-1:0] cfg_delay,
  input  logic [31:0]        cfg_bit,
  input  logic [7:0]         cfg_len,
  input  logic [CYCLE_W-1:0] cfg_period,
  input  logic [7:0]         cfg_count,
  input  logic               abort,
  output logic [31:0]        verinject__injector_state,
  output logic               busy,
  output logic               done,
  output logic [7:0]         inject_count
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_INJECT} state_e;

  state_e             state_q, state_d;
  logic [CYCLE_W-1:0] delay_q, delay_d;
  logic [7:0]         len_q,   len_d;    // remaining cycles in current window
  logic [7:0]         lcfg_q,  lcfg_d;   // latched window length
  logic [31:0]        bit_q,   bit_d;
  logic [31:0]        out_q,   out_d;
  logic [7:0]         cnt_q,   cnt_d;
  logic               done_q,  done_d;
`ifdef VERINJECT_SEQ_REPEAT_EN
  logic [CYCLE_W-1:0] per_q,   per_d;
  logic [7:0]         tot_q,   tot_d;
  logic [7:0]         tot_eff;
  logic [31:0]        bit_inc;
  assign tot_eff = (tot_q == 8'd0) ? 8'd1 : tot_q;
  assign bit_inc = bit_q + 32'd1;
`else
  logic unused_cfg;
  assign unused_cfg = ^{cfg_period, cfg_count};
`endif

  assign cfg_ready                 = (state_q == S_IDLE) && !abort;
  assign busy                      = (state_q != S_IDLE);
  assign done                      = done_q;
  assign inject_count              = cnt_q;
  assign verinject__injector_state = out_q;

  // Next-state and datapath: abort overrides everything, then per-state work
  always_comb begin
    state_d = state_q;
    delay_d = delay_q;
    len_d   = len_q;
    lcfg_d  = lcfg_q;
    bit_d   = bit_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
`ifdef VERINJECT_SEQ_REPEAT_EN
    per_d   = per_q;
    tot_d   = tot_q;
`endif
    if (abort) begin
      state_d = S_IDLE;
      out_d   = IDLE_STATE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cfg_valid) begin
            state_d = S_ARMED;
            delay_d = cfg_delay;
            bit_d   = cfg_bit;
            lcfg_d  = cfg_len;
            cnt_d   = 8'd0;
`ifdef VERINJECT_SEQ_REPEAT_EN
            per_d   = cfg_period;
            tot_d   = cfg_count;
`endif
          end
        end
        S_ARMED: begin
          if (delay_q == '0) begin
            state_d = S_INJECT;
            out_d   = bit_q;
            len_d   = (lcfg_q == 8'd0) ? 8'd0 : lcfg_q - 8'd1;
            cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
          end else begin
            delay_d = delay_q - CYCLE_W'(1);
          end
        end
        S_INJECT: begin
          if (len_q == 8'd0) begin
            out_d = IDLE_STATE;
`ifdef VERINJECT_SEQ_REPEAT_EN
            if (cnt_q < tot_eff) begin
              // Another window: re-arm with the period, step the bit,
              // skipping the idle code so the injection stays visible.
              state_d = S_ARMED;
              delay_d = per_q;
              bit_d   = (bit_inc == IDLE_STATE) ? 32'd0 : bit_inc;
            end else begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
`else
            state_d = S_IDLE;
            done_d  = 1'b1;
`endif
          end else begin
            len_d = len_q - 8'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State register; reset drops everything back to idle immediately
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      delay_q <= '0;
      len_q   <= 8'd0;
      lcfg_q  <= 8'd0;
      bit_q   <= 32'd0;
      out_q   <= IDLE_STATE;
      cnt_q   <= 8'd0;
      done_q  <= 1'b0;
`ifdef VERINJECT_SEQ_REPEAT_EN
      per_q   <= '0;
      tot_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      delay_q <= delay_d;
      len_q   <= len_d;
      lcfg_q  <= lcfg_d;
      bit_q   <= bit_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
`ifdef VERINJECT_SEQ_REPEAT_EN
      per_q   <= per_d;
      tot_q   <= tot_d;
`endif
    end
  end

endmodule

// File: tb/tb_verinject_injection_sequencer.sv
// Scoreboard bench: a timeline model predicts every cycle's outputs from
// job parameters and acceptance edge; a negedge monitor pops and compares.
module tb_verinject_injection_sequencer;
  localparam logic [31:0] IDLE = 32'hFFFF_FFFF;

  logic        clock = 1'b0, reset_n = 1'b0, cfg_valid = 1'b0, abort = 1'b0;
  logic        cfg_ready, busy, done;
  logic [31:0] cfg_delay = '0, cfg_bit = '0, cfg_period = '0, inj_state;
  logic [7:0]  cfg_len = '0, cfg_count = '0, inject_count;

  verinject_injection_sequencer #(.IDLE_STATE(IDLE), .CYCLE_W(32)) dut (
    .clock(clock), .reset_n(reset_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_delay(cfg_delay), .cfg_bit(cfg_bit), .cfg_len(cfg_len),
    .cfg_period(cfg_period), .cfg_count(cfg_count), .abort(abort),
    .verinject__injector_state(inj_state), .busy(busy), .done(done),
    .inject_count(inject_count));

  always #5 clock = ~clock;

  typedef struct packed { logic [31:0] d, b, p; logic [7:0] l, c; } job_t;
  typedef struct packed { logic [31:0] out; logic busy, done, ready; logic [7:0] cnt; } exp_t;

  exp_t   sb_q[$];
  int     n_chk = 0, n_pass = 0;
  longint ecur = 0;

  // Reference model: one job described by its acceptance edge and parameters
  bit          m_act = 1'b0;
  longint      m_k, m_d, m_lr, m_p, m_n;
  logic [31:0] m_b0;
  logic [7:0]  m_hold = 8'd0;

  function automatic logic [31:0] nth_bit(int i);
    logic [31:0] b = m_b0;
    repeat (i) b = (b + 32'd1 == IDLE) ? 32'd0 : b + 32'd1;
    return b;
  endfunction

  function automatic longint m_end();
    return m_k + m_d + 1 + (m_n - 1) * (m_lr + m_p + 1) + m_lr;
  endfunction

  function automatic exp_t model_at(longint e);
    exp_t   x;
    longint s, t, per;
    x.out = IDLE; x.busy = 1'b0; x.done = 1'b0; x.ready = 1'b0; x.cnt = m_hold;
    if (m_act) begin
      s   = m_k + m_d + 1;
      per = m_lr + m_p + 1;
      if (e >= m_end()) begin
        x.cnt  = 8'(m_n);
        x.done = (e == m_end());
      end else begin
        x.busy = 1'b1;
        if (e < s) x.cnt = 8'd0;
        else begin
          t     = e - s;
          x.cnt = 8'(t / per + 1);
          if (t % per < m_lr) x.out = nth_bit(int'(t / per));
        end
      end
    end
    return x;
  endfunction

  task automatic chk(input string nm, input longint a, input longint x);
    n_chk++;
    if (a == x) n_pass++;
    else $display("FAIL %s at edge %0d: got %0h expected %0h", nm, ecur, a, x);
  endtask

  // Monitor: every cycle the DUT presents its outputs, compare with the queue
  always @(negedge clock) begin
    if (sb_q.size() > 0) begin
      exp_t x;
      x = sb_q.pop_front();
      chk("state_word", longint'(inj_state), longint'(x.out));
      chk("busy", longint'(busy), longint'(x.busy));
      chk("done", longint'(done), longint'(x.done));
      chk("cfg_ready", longint'(cfg_ready), longint'(x.ready));
      chk("inject_count", longint'(inject_count), longint'(x.cnt));
    end
  end

  // One clock of stimulus: drive inputs, push expectation, advance the model
  task automatic step(input logic rn, input logic ab, input logic v, input job_t j, output bit acc);
    exp_t x;
    @(posedge clock); #1;
    ecur++;
    reset_n = rn;
    if (!rn) begin m_act = 1'b0; m_hold = 8'd0; end
    abort = ab; cfg_valid = v && rn;
    cfg_delay = j.d; cfg_bit = j.b; cfg_len = j.l; cfg_period = j.p; cfg_count = j.c;
    x = model_at(ecur);
    x.ready = !x.busy && !ab;
    sb_q.push_back(x);
    acc = 1'b0;
    if (rn) begin
      if (ab) begin
        if (m_act) m_hold = x.cnt;
        m_act = 1'b0;
      end else if (v && x.ready) begin
        acc = 1'b1; m_act = 1'b1; m_k = ecur + 1; m_d = j.d; m_b0 = j.b;
        m_lr = (j.l == 0) ? 1 : j.l;
`ifdef VERINJECT_SEQ_REPEAT_EN
        m_p = j.p; m_n = (j.c == 0) ? 1 : j.c;
`else
        m_p = 0; m_n = 1;
`endif
      end
    end
  endtask

  task automatic send(input job_t j);
    bit a = 1'b0;
    int n = 0;
    while (!a && n < 2000) begin step(1'b1, 1'b0, 1'b1, j, a); n++; end
    chk("accept_timeout", longint'(a), 1);
  endtask

  task automatic drain(input int abort_at);
    job_t jz = '0;
    bit   a;
    int   n = 0;
    while (m_act && ecur < m_end() + 1 && n < 2000) begin
      step(1'b1, (n == abort_at), 1'b0, jz, a);
      n++;
    end
    chk("drain_timeout", longint'(n < 2000), 1);
  endtask

  task automatic idle(input int n);
    job_t jz = '0;
    bit   a;
    repeat (n) step(1'b1, 1'b0, 1'b0, jz, a);
  endtask

  function automatic job_t mk(logic [31:0] d, logic [31:0] b, logic [7:0] l, logic [31:0] p, logic [7:0] c);
    job_t j;
    j.d = d; j.b = b; j.l = l; j.p = p; j.c = c;
    return j;
  endfunction

  initial begin
    job_t jz = '0;
    job_t j;
    bit   a;
    // reset held, then released
    repeat (3) step(1'b0, 1'b0, 1'b0, jz, a);
    idle(2);
    // single injection
    send(mk(3, 5, 2, 0, 1));       drain(-1); idle(2);
    // zero delay, zero length
    send(mk(0, 32'h1234, 0, 0, 0)); drain(-1); idle(2);
    // abort mid-window
    send(mk(1, 9, 5, 0, 1));       drain(4);  idle(2);
    // abort together with valid: not accepted
    step(1'b1, 1'b1, 1'b1, mk(0, 11, 1, 0, 1), a);
    idle(3);
    // repeated injections
    send(mk(0, 7, 1, 2, 3));       drain(-1); idle(2);
    // back-pressure: second job waits for the done cycle; bit wrap
    send(mk(2, 32'hFFFF_FFFE, 2, 1, 2));
    send(mk(0, 40, 1, 0, 1));      drain(-1); idle(2);
    // reset mid-job
    send(mk(0, 3, 8, 0, 1));
    idle(3);
    repeat (2) step(1'b0, 1'b0, 1'b0, jz, a);
    idle(2);
    // randomized jobs
    for (int r = 0; r < 30; r++) begin
      j = mk($urandom_range(0, 5), $urandom, 8'($urandom_range(0, 4)),
             $urandom_range(0, 3), 8'($urandom_range(0, 4)));
      if (j.b == IDLE) j.b = 32'd0;
      send(j);
      if ($urandom_range(0, 2) == 0) begin
        j.b = j.b ^ 32'h55;
        if (j.b == IDLE) j.b = 32'd0;
        send(j);
      end
      drain(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : -1);
      idle($urandom_range(0, 2));
    end
    @(negedge clock); #1;
    chk("scoreboard_empty", longint'(sb_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
